// File: rtl/lif_window_classifier.sv
// rtl/lif_window_classifier.sv - windowed adaptive-threshold LIF layer with spike counters and sequential argmax
// Optional feature macro: LIF_WEIGHT_LOAD_EN (per-neuron weight registers, loadable while IDLE)
module lif_window_classifier #(
   parameter int N_NEURONS   = 10,
   parameter int WIDTH       = 8,
   parameter int WINDOW      = 64,
   parameter int THRESHOLD   = 128,
   parameter int THRESH_INC  = 20,
   parameter int THRESH_DEC  = 1,
   parameter int THRESH_MIN  = 75,
   parameter int LEAK_SHIFT  = 1,
   parameter int W_SHIFT     = 0,
   parameter int WEIGHT_INIT = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         busy_o,
   output logic [N_NEURONS-1:0]         spikes_o,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic [$clog2(N_NEURONS)-1:0] class_o,
   output logic [WIDTH-1:0]             count_o
`ifdef LIF_WEIGHT_LOAD_EN
   ,
   input  logic                         wl_en_i,
   input  logic [$clog2(N_NEURONS)-1:0] wl_addr_i,
   input  logic [WIDTH-1:0]             wl_data_i
`endif
);

   localparam int IW  = $clog2(N_NEURONS);
   localparam int SW  = $clog2(WINDOW + 1);
   localparam int PW  = 2 * WIDTH;
   localparam int WP1 = WIDTH + 1;

   localparam logic [WIDTH-1:0] VMAX      = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] THR_INIT  = WIDTH'(THRESHOLD);
   localparam logic [WIDTH-1:0] THR_MIN   = WIDTH'(THRESH_MIN);
   localparam logic [WIDTH-1:0] THR_DEC   = WIDTH'(THRESH_DEC);
   localparam logic [WP1-1:0]   THR_INC   = WP1'(THRESH_INC);
   localparam logic [WP1-1:0]   DN_LIMIT  = WP1'(THRESH_MIN + THRESH_DEC);
   localparam logic [WIDTH-1:0] W_INIT    = WIDTH'(WEIGHT_INIT);
   localparam logic [SW-1:0]    LAST_STEP = SW'(WINDOW - 1);
   localparam logic [IW-1:0]    LAST_IDX  = IW'(N_NEURONS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

   state_t                 fsm_q, fsm_d;
   logic [WIDTH-1:0]       mem_q [N_NEURONS];
   logic [WIDTH-1:0]       mem_d [N_NEURONS];
   logic [WIDTH-1:0]       thr_q [N_NEURONS];
   logic [WIDTH-1:0]       thr_d [N_NEURONS];
   logic [WIDTH-1:0]       cnt_q [N_NEURONS];
   logic [WIDTH-1:0]       cnt_d [N_NEURONS];
   logic [SW-1:0]          step_q, step_d;
   logic [IW-1:0]          scan_idx_q, scan_idx_d;
   logic [IW-1:0]          max_idx_q, max_idx_d;
   logic [WIDTH-1:0]       max_cnt_q, max_cnt_d;
   logic [IW-1:0]          class_q, class_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic [N_NEURONS-1:0]   spikes_q, spikes_d;
   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;
   logic                   res_valid_q, res_valid_d;

   logic [WIDTH-1:0]       weight [N_NEURONS];
   logic [PW-1:0]          prod_sh [N_NEURONS];
   logic [WIDTH-1:0]       cur [N_NEURONS];
   logic [WP1-1:0]         v_sum [N_NEURONS];
   logic [WIDTH-1:0]       v_sat [N_NEURONS];
   logic [WP1-1:0]         thr_up [N_NEURONS];
   logic [WIDTH-1:0]       mem_nx [N_NEURONS];
   logic [WIDTH-1:0]       thr_nx [N_NEURONS];
   logic [WIDTH-1:0]       cnt_nx [N_NEURONS];
   logic [N_NEURONS-1:0]   spk_nx;
   logic                   scan_better;

`ifdef LIF_WEIGHT_LOAD_EN
   logic [WIDTH-1:0]       w_q [N_NEURONS];
   logic [WIDTH-1:0]       w_d [N_NEURONS];

   // Weights come from the loadable registers
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         weight[i] = w_q[i];
      end
   end
`else
   // Every weight is the fixed initial value
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         weight[i] = W_INIT;
      end
   end
`endif

   // Candidate next neuron state for one accepted timestep, all arithmetic saturating
   always_comb begin
      for (int i = 0; i < N_NEURONS; i++) begin
         prod_sh[i] = (PW'(in_data_i) * PW'(weight[i])) >> W_SHIFT;
         cur[i]     = (prod_sh[i] > PW'(VMAX)) ? VMAX : prod_sh[i][WIDTH-1:0];
         v_sum[i]   = WP1'(mem_q[i] - (mem_q[i] >> LEAK_SHIFT)) + WP1'(cur[i]);
         v_sat[i]   = v_sum[i][WIDTH] ? VMAX : v_sum[i][WIDTH-1:0];
         thr_up[i]  = WP1'(thr_q[i]) + THR_INC;
         spk_nx[i]  = (v_sat[i] >= thr_q[i]);
         if (spk_nx[i]) begin
            mem_nx[i] = '0;
            thr_nx[i] = thr_up[i][WIDTH] ? VMAX : thr_up[i][WIDTH-1:0];
            cnt_nx[i] = (cnt_q[i] == VMAX) ? VMAX : cnt_q[i] + 1'b1;
         end else begin
            mem_nx[i] = v_sat[i];
            thr_nx[i] = (WP1'(thr_q[i]) >= DN_LIMIT) ? (thr_q[i] - THR_DEC) : THR_MIN;
            cnt_nx[i] = cnt_q[i];
         end
      end
   end

   // Control FSM: window setup, per-step commit, argmax scan and result hold
   always_comb begin
      fsm_d       = fsm_q;
      step_d      = step_q;
      scan_idx_d  = scan_idx_q;
      max_idx_d   = max_idx_q;
      max_cnt_d   = max_cnt_q;
      class_d     = class_q;
      count_d     = count_q;
      spikes_d    = spikes_q;
      scan_better = 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
         mem_d[i] = mem_q[i];
         thr_d[i] = thr_q[i];
         cnt_d[i] = cnt_q[i];
`ifdef LIF_WEIGHT_LOAD_EN
         w_d[i]   = w_q[i];
`endif
      end

      case (fsm_q)
         S_IDLE: begin
            if (start_i) begin
               fsm_d    = S_RUN;
               step_d   = '0;
               spikes_d = '0;
               for (int i = 0; i < N_NEURONS; i++) begin
                  mem_d[i] = '0;
                  thr_d[i] = THR_INIT;
                  cnt_d[i] = '0;
               end
            end
`ifdef LIF_WEIGHT_LOAD_EN
            // Out-of-range addresses are dropped so a narrow address bus cannot alias
            if (wl_en_i && (32'(wl_addr_i) < 32'(N_NEURONS))) begin
               w_d[wl_addr_i] = wl_data_i;
            end
`endif
         end
         S_RUN: begin
            if (in_valid_i && in_ready_q) begin
               for (int i = 0; i < N_NEURONS; i++) begin
                  mem_d[i] = mem_nx[i];
                  thr_d[i] = thr_nx[i];
                  cnt_d[i] = cnt_nx[i];
               end
               spikes_d = spk_nx;
               if (step_q == LAST_STEP) begin
                  fsm_d      = S_SCAN;
                  scan_idx_d = '0;
                  max_idx_d  = '0;
                  max_cnt_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         S_SCAN: begin
            // Strict compare keeps the lowest index on ties
            scan_better = (cnt_q[scan_idx_q] > max_cnt_q);
            if (scan_better) begin
               max_idx_d = scan_idx_q;
               max_cnt_d = cnt_q[scan_idx_q];
            end
            if (scan_idx_q == LAST_IDX) begin
               class_d = max_idx_d;
               count_d = max_cnt_d;
               fsm_d   = S_DONE;
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_ready_i) begin
               fsm_d = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase

      in_ready_d  = (fsm_d == S_RUN);
      busy_d      = (fsm_d != S_IDLE);
      res_valid_d = (fsm_d == S_DONE);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         step_q      <= '0;
         scan_idx_q  <= '0;
         max_idx_q   <= '0;
         max_cnt_q   <= '0;
         class_q     <= '0;
         count_q     <= '0;
         spikes_q    <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            mem_q[i] <= '0;
            thr_q[i] <= THR_INIT;
            cnt_q[i] <= '0;
`ifdef LIF_WEIGHT_LOAD_EN
            w_q[i]   <= W_INIT;
`endif
         end
      end else begin
         fsm_q       <= fsm_d;
         step_q      <= step_d;
         scan_idx_q  <= scan_idx_d;
         max_idx_q   <= max_idx_d;
         max_cnt_q   <= max_cnt_d;
         class_q     <= class_d;
         count_q     <= count_d;
         spikes_q    <= spikes_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         for (int i = 0; i < N_NEURONS; i++) begin
            mem_q[i] <= mem_d[i];
            thr_q[i] <= thr_d[i];
            cnt_q[i] <= cnt_d[i];
`ifdef LIF_WEIGHT_LOAD_EN
            w_q[i]   <= w_d[i];
`endif
         end
      end
   end

   assign in_ready_o  = in_ready_q;
   assign busy_o      = busy_q;
   assign res_valid_o = res_valid_q;
   assign spikes_o    = spikes_q;
   assign class_o     = class_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_lif_window_classifier.sv
// tb/tb_lif_window_classifier.sv - directed-vector bench for lif_window_classifier
module tb_lif_window_classifier;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic [7:0] in_data_i = 8'd0;
   logic       res_ready_i = 1'b0;
   logic       in_ready_o, busy_o, res_valid_o;
   logic [9:0] spikes_o;
   logic [3:0] class_o;
   logic [7:0] count_o;

   logic       start_s = 1'b0;
   logic       valid_s = 1'b0;
   logic [7:0] data_s = 8'd0;
   logic       rr_s = 1'b0;
   logic       ready_s, busy_s, rv_s;
   logic [9:0] spikes_s;
   logic [3:0] class_s;
   logic [7:0] count_s;

`ifdef LIF_WEIGHT_LOAD_EN
   logic       wl_en = 1'b0;
   logic [3:0] wl_addr = 4'd0;
   logic [7:0] wl_data = 8'd0;
   logic       wl_en_s = 1'b0;
   logic [3:0] wl_addr_s = 4'd0;
   logic [7:0] wl_data_s = 8'd0;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lif_window_classifier dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .busy_o(busy_o), .spikes_o(spikes_o), .res_valid_o(res_valid_o),
      .res_ready_i(res_ready_i), .class_o(class_o), .count_o(count_o)
`ifdef LIF_WEIGHT_LOAD_EN
      , .wl_en_i(wl_en), .wl_addr_i(wl_addr), .wl_data_i(wl_data)
`endif
   );

   lif_window_classifier #(.WINDOW(300)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start_i(start_s),
      .in_valid_i(valid_s), .in_ready_o(ready_s), .in_data_i(data_s),
      .busy_o(busy_s), .spikes_o(spikes_s), .res_valid_o(rv_s),
      .res_ready_i(rr_s), .class_o(class_s), .count_o(count_s)
`ifdef LIF_WEIGHT_LOAD_EN
      , .wl_en_i(wl_en_s), .wl_addr_i(wl_addr_s), .wl_data_i(wl_data_s)
`endif
   );

   task automatic run_window(input logic [7:0] data, input bit toggle,
                             output logic st_busy, output logic st_rdy,
                             output logic rdy_after, output logic [9:0] spk_or,
                             output int lat);
      int acc;
      int cyc;
      acc = 0;
      cyc = 0;
      lat = -1;
      spk_or = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      st_busy = busy_o;
      st_rdy  = in_ready_o;
      while (acc < 64 && cyc < 400) begin
         in_valid_i = toggle ? (cyc[0] == 1'b0) : 1'b1;
         in_data_i  = data;
         spk_or     = spk_or | spikes_o;
         if (in_valid_i && in_ready_o) acc++;
         @(negedge clk);
         cyc++;
      end
      in_valid_i = 1'b0;
      rdy_after = in_ready_o;
      for (int k = 1; k <= 40; k++) begin
         spk_or = spk_or | spikes_o;
         if (res_valid_o) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic finish_result();
      res_ready_i = 1'b1;
      @(negedge clk);
      res_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 0", in_ready_o); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
      vectors++; if (res_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %0b want 0", res_valid_o); end
      vectors++; if (spikes_o !== 10'h000) begin miscompares++; $display("FAIL reset_spikes: got %h want 000", spikes_o); end
      vectors++; if (class_o !== 4'd0) begin miscompares++; $display("FAIL reset_class: got %0d want 0", class_o); end
      vectors++; if (count_o !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count_o); end
   endtask

   task automatic test_zero_input();
      logic sb, sr, ra;
      logic [9:0] so;
      int lat;
      run_window(8'd0, 1'b0, sb, sr, ra, so, lat);
      vectors++; if (sb !== 1'b1) begin miscompares++; $display("FAIL zero_start_busy: got %0b want 1", sb); end
      vectors++; if (sr !== 1'b1) begin miscompares++; $display("FAIL zero_start_ready: got %0b want 1", sr); end
      vectors++; if (so !== 10'h000) begin miscompares++; $display("FAIL zero_spikes: got %h want 000", so); end
      vectors++; if (ra !== 1'b0) begin miscompares++; $display("FAIL zero_ready_after_last: got %0b want 0", ra); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL zero_latency: got %0d want 11", lat); end
      vectors++; if (class_o !== 4'd0) begin miscompares++; $display("FAIL zero_class: got %0d want 0", class_o); end
      vectors++; if (count_o !== 8'd0) begin miscompares++; $display("FAIL zero_count: got %0d want 0", count_o); end
      finish_result();
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_idle_after_ack: got %0b want 0", busy_o); end
   endtask

   task automatic test_uniform();
      logic sb, sr, ra;
      logic [9:0] so;
      int lat;
      run_window(8'd255, 1'b0, sb, sr, ra, so, lat);
      vectors++; if (so !== 10'h3ff) begin miscompares++; $display("FAIL uniform_spikes: got %h want 3ff", so); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL uniform_latency: got %0d want 11", lat); end
      vectors++; if (class_o !== 4'd0) begin miscompares++; $display("FAIL uniform_class: got %0d want 0", class_o); end
      vectors++; if (count_o !== 8'd64) begin miscompares++; $display("FAIL uniform_count: got %0d want 64", count_o); end
      finish_result();
   endtask

   task automatic test_moderate_input();
      int k;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int s = 0; s < 64; s++) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'd60;
         @(negedge clk);
         if (s == 0 || s == 7 || s == 9) begin
            vectors++; if (spikes_o !== 10'h000) begin miscompares++; $display("FAIL mod_spikes_step%0d: got %h want 000", s, spikes_o); end
         end
         if (s == 8) begin
            vectors++; if (spikes_o !== 10'h3ff) begin miscompares++; $display("FAIL mod_spikes_step8: got %h want 3ff", spikes_o); end
         end
      end
      in_valid_i = 1'b0;
      k = 0;
      while (!res_valid_o && k < 40) begin @(negedge clk); k++; end
      vectors++; if (res_valid_o !== 1'b1) begin miscompares++; $display("FAIL mod_valid: got %0b want 1", res_valid_o); end
      vectors++; if (class_o !== 4'd0) begin miscompares++; $display("FAIL mod_class: got %0d want 0", class_o); end
      vectors++; if (count_o !== 8'd3) begin miscompares++; $display("FAIL mod_count: got %0d want 3", count_o); end
      finish_result();
   endtask

   task automatic test_handshakes();
      logic sb, sr, ra;
      logic [9:0] so;
      int lat;
      int bad;
      run_window(8'd255, 1'b1, sb, sr, ra, so, lat);
      vectors++; if (count_o !== 8'd64) begin miscompares++; $display("FAIL toggle_count: got %0d want 64", count_o); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL toggle_latency: got %0d want 11", lat); end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         start_i = (c == 5);
         @(negedge clk);
         if (res_valid_o !== 1'b1 || class_o !== 4'd0 || count_o !== 8'd64 ||
             busy_o !== 1'b1 || in_ready_o !== 1'b0) bad++;
      end
      start_i = 1'b0;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
      start_i = 1'b1;
      res_ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      res_ready_i = 1'b0;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL ack_start_busy: got %0b want 0", busy_o); end
      @(negedge clk);
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL ack_start_ready: got %0b want 0", in_ready_o); end
   endtask

   task automatic test_start_in_run();
      int acc;
      int cyc;
      int k;
      acc = 0;
      cyc = 0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      while (acc < 64 && cyc < 200) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'd255;
         start_i    = (acc == 30);
         if (in_ready_o) acc++;
         @(negedge clk);
         cyc++;
      end
      in_valid_i = 1'b0;
      start_i = 1'b0;
      k = 1;
      while (!res_valid_o && k < 40) begin @(negedge clk); k++; end
      vectors++; if (k != 11) begin miscompares++; $display("FAIL run_start_latency: got %0d want 11", k); end
      vectors++; if (count_o !== 8'd64) begin miscompares++; $display("FAIL run_start_count: got %0d want 64", count_o); end
      finish_result();
   endtask

   task automatic test_reset_mid_run();
      logic sb, sr, ra;
      logic [9:0] so;
      int lat;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'd255;
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0b want 0", busy_o); end
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %0b want 0", in_ready_o); end
      vectors++; if (spikes_o !== 10'h000) begin miscompares++; $display("FAIL midrst_spikes: got %h want 000", spikes_o); end
      run_window(8'd60, 1'b0, sb, sr, ra, so, lat);
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL midrst_latency: got %0d want 11", lat); end
      vectors++; if (count_o !== 8'd3) begin miscompares++; $display("FAIL midrst_count: got %0d want 3", count_o); end
      finish_result();
   endtask

   task automatic test_saturation();
      int acc;
      int cyc;
      int k;
      int busy_bad;
      acc = 0;
      cyc = 0;
      busy_bad = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      while (acc < 300 && cyc < 1000) begin
         valid_s = 1'b1;
         data_s  = 8'd255;
         if (busy_s !== 1'b1) busy_bad++;
         if (ready_s) acc++;
         @(negedge clk);
         cyc++;
      end
      valid_s = 1'b0;
      k = 0;
      while (!rv_s && k < 40) begin @(negedge clk); k++; end
      vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL sat_busy: got %0d idle cycles want 0", busy_bad); end
      vectors++; if (rv_s !== 1'b1) begin miscompares++; $display("FAIL sat_valid: got %0b want 1", rv_s); end
      vectors++; if (spikes_s !== 10'h3ff) begin miscompares++; $display("FAIL sat_spikes: got %h want 3ff", spikes_s); end
      vectors++; if (class_s !== 4'd0) begin miscompares++; $display("FAIL sat_class: got %0d want 0", class_s); end
      vectors++; if (count_s !== 8'd255) begin miscompares++; $display("FAIL sat_count: got %0d want 255", count_s); end
      rr_s = 1'b1;
      @(negedge clk);
      rr_s = 1'b0;
   endtask

`ifdef LIF_WEIGHT_LOAD_EN
   task automatic test_weight_load();
      int acc;
      int cyc;
      int k;
      wl_en = 1'b1; wl_addr = 4'd3; wl_data = 8'd2;
      @(negedge clk);
      wl_addr = 4'd12; wl_data = 8'd200;
      @(negedge clk);
      wl_en = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 64 && cyc < 200) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'd60;
         wl_en      = (acc == 2);
         wl_addr    = 4'd5;
         wl_data    = 8'd200;
         if (in_ready_o) acc++;
         @(negedge clk);
         cyc++;
      end
      in_valid_i = 1'b0;
      wl_en = 1'b0;
      k = 0;
      while (!res_valid_o && k < 40) begin @(negedge clk); k++; end
      vectors++; if (res_valid_o !== 1'b1) begin miscompares++; $display("FAIL wl_valid: got %0b want 1", res_valid_o); end
      vectors++; if (class_o !== 4'd3) begin miscompares++; $display("FAIL wl_class: got %0d want 3", class_o); end
      vectors++; if (!(count_o > 8'd3)) begin miscompares++; $display("FAIL wl_count: got %0d want >3", count_o); end
      finish_result();
   endtask
`endif

   initial begin
      test_reset();
      test_zero_input();
      test_uniform();
      test_moderate_input();
      test_handshakes();
      test_start_in_run();
      test_reset_mid_run();
      test_saturation();
`ifdef LIF_WEIGHT_LOAD_EN
      test_weight_load();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
